// File: rtl/edge_detect_pkg.sv
// edge_detect_pkg: edge-mode encoding shared by the multi-channel edge detector.
package edge_detect_pkg;
    typedef enum logic [1:0] {
        EDGE_OFF  = 2'd0,
        EDGE_RISE = 2'd1,
        EDGE_FALL = 2'd2,
        EDGE_BOTH = 2'd3
    } edge_mode_e;
endpackage

// File: rtl/edge_detect_chan.sv
// edge_detect_chan: one channel - synchroniser, debounce filter, edge select, sticky pending.
module edge_detect_chan
    import edge_detect_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       level,
    input  logic [1:0] mode,
    input  logic       clr_pending,
    output logic       tick,
    output logic       pending,
    output logic       level_db
);
    localparam int D  = DEBOUNCE_CYCLES > 1 ? DEBOUNCE_CYCLES : 1;
    localparam int CW = $clog2(D + 1);
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt;
    logic                   synced, stable_q, stable_prev, rise, fall, hit;
    edge_mode_e             md;
    assign md       = edge_mode_e'(mode);
    assign synced   = sync_q[SYNC_STAGES-1];
    assign rise     = stable_q & ~stable_prev;
    assign fall     = ~stable_q & stable_prev;
    assign level_db = stable_q;
    always_comb begin
        hit = md == EDGE_RISE ? rise :
              md == EDGE_FALL ? fall :
              md == EDGE_BOTH ? (rise | fall) : 1'b0;
    end
    // a new level must be seen D cycles in a row before it replaces stable_q
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q      <= '0;
            cnt         <= '0;
            stable_q    <= 1'b0;
            stable_prev <= 1'b0;
            tick        <= 1'b0;
            pending     <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], level};
            stable_prev <= stable_q;
            tick        <= hit;
            pending     <= tick | (pending & ~clr_pending);
            if (synced == stable_q) begin
                cnt <= '0;
            end else if (cnt == CW'(D - 1)) begin
                stable_q <= synced;
                cnt      <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/edge_detect_multi.sv
// edge_detect_multi: N independent filtered edge-detect channels with an aggregate tick.
module edge_detect_multi
    import edge_detect_pkg::*;
#(
    parameter int N_CH            = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_CH-1:0]   level,
    input  logic [2*N_CH-1:0] mode,
    input  logic [N_CH-1:0]   clr_pending,
    output logic [N_CH-1:0]   tick,
    output logic [N_CH-1:0]   pending,
    output logic [N_CH-1:0]   level_db,
    output logic              any_tick
);
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        edge_detect_chan #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_chan (
            .clk        (clk),
            .reset      (reset),
            .level      (level[i]),
            .mode       (mode[2*i +: 2]),
            .clr_pending(clr_pending[i]),
            .tick       (tick[i]),
            .pending    (pending[i]),
            .level_db   (level_db[i])
        );
    end
    assign any_tick = |tick;
endmodule

// File: tb/tb_edge_detect_multi.sv
// tb_edge_detect_multi: directed scenarios plus randomized traffic against a history-based model,
// on one unfiltered instance (a) and one with a 4-cycle debounce (b).
module tb_edge_detect_multi;
    localparam int S = 2;
    localparam int DD [2] = '{1, 4};
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] level = '0;
    logic [3:0] clr_pending = '0;
    logic [7:0] mode = '0;
    logic [3:0] tick_a, pend_a, ldb_a, tick_b, pend_b, ldb_b;
    logic       any_a, any_b;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    edge_detect_multi #(.N_CH(4), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(0)) dut_a (
        .clk(clk), .reset(reset), .level(level), .mode(mode), .clr_pending(clr_pending),
        .tick(tick_a), .pending(pend_a), .level_db(ldb_a), .any_tick(any_a)
    );
    edge_detect_multi #(.N_CH(4), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(4)) dut_b (
        .clk(clk), .reset(reset), .level(level), .mode(mode), .clr_pending(clr_pending),
        .tick(tick_b), .pending(pend_b), .level_db(ldb_b), .any_tick(any_b)
    );

    // Reference: keep the raw sampled level history; the filtered level flips once the
    // last D samples seen after the synchroniser delay all disagree with it.
    bit       hist [2][4][16];
    bit [3:0] mst [2];
    bit [3:0] mpr [2];
    bit [3:0] etick [2];
    bit [3:0] epend [2];
    always begin : model
        logic [1:0] md;
        logic       r, f, flip;
        @(posedge clk or posedge reset);
        if (reset) begin
            for (int u = 0; u < 2; u++) begin
                mst[u] = '0; mpr[u] = '0; etick[u] = '0; epend[u] = '0;
                for (int c = 0; c < 4; c++)
                    for (int j = 0; j < 16; j++) hist[u][c][j] = 1'b0;
            end
        end else begin
            for (int u = 0; u < 2; u++) begin
                epend[u] = etick[u] | (epend[u] & ~clr_pending);
                for (int c = 0; c < 4; c++) begin
                    md = mode[2*c +: 2];
                    r  = mst[u][c] & ~mpr[u][c];
                    f  = ~mst[u][c] & mpr[u][c];
                    etick[u][c] = (md == 2'd1 && r) || (md == 2'd2 && f) || (md == 2'd3 && (r || f));
                    for (int j = 15; j > 0; j--) hist[u][c][j] = hist[u][c][j-1];
                    hist[u][c][0] = level[c];
                    flip = 1'b1;
                    for (int j = S; j < S + DD[u]; j++)
                        if (hist[u][c][j] == mst[u][c]) flip = 1'b0;
                    mpr[u][c] = mst[u][c];
                    if (flip) mst[u][c] = ~mst[u][c];
                end
            end
        end
    end

    task automatic settle();
        mode  = '0;
        level = '0;
        repeat (12) @(negedge clk);
        clr_pending = 4'hF;
        @(negedge clk);
        clr_pending = '0;
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #2;
        checks++;
        if ({tick_a, pend_a, ldb_a, any_a, tick_b, pend_b, ldb_b, any_b} !== 26'd0) begin
            failures++;
            $display("FAIL reset_state got a=%b/%b/%b/%b b=%b/%b/%b/%b want all zero",
                     tick_a, pend_a, ldb_a, any_a, tick_b, pend_b, ldb_b, any_b);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic_rise();
        settle();
        mode     = 8'b00_00_00_01;
        level[0] = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            checks++;
            if (tick_a[0] !== (n == 4)) begin
                failures++;
                $display("FAIL basic_tick n=%0d got=%b want=%b", n, tick_a[0], n == 4);
            end
            checks++;
            if (pend_a[0] !== (n >= 5 && n <= 7)) begin
                failures++;
                $display("FAIL basic_pending n=%0d got=%b want=%b", n, pend_a[0], n >= 5 && n <= 7);
            end
            clr_pending[0] = (n == 7);
        end
    endtask

    task automatic test_debounce();
        settle();
        mode     = 8'hFF;
        level[0] = 1'b1;
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            checks++;
            if (tick_b[0] !== 1'b0 || ldb_b[0] !== 1'b0) begin
                failures++;
                $display("FAIL debounce_short n=%0d got tick=%b db=%b want 0/0", n, tick_b[0], ldb_b[0]);
            end
            if (n == 3) level[0] = 1'b0;
        end
        level[0] = 1'b1;
        for (int n = 1; n <= 18; n++) begin
            @(negedge clk);
            checks++;
            if (tick_b[0] !== (n == 7 || n == 13)) begin
                failures++;
                $display("FAIL debounce_tick n=%0d got=%b want=%b", n, tick_b[0], n == 7 || n == 13);
            end
            if (n == 7 || n == 13) begin
                checks++;
                if (ldb_b[0] !== (n == 7)) begin
                    failures++;
                    $display("FAIL debounce_dir n=%0d got db=%b want=%b", n, ldb_b[0], n == 7);
                end
            end
            if (n == 6) level[0] = 1'b0;
        end
    endtask

    task automatic test_all_channels();
        logic [3:0] want;
        settle();
        mode  = 8'b11_10_01_00;
        level = 4'hF;
        for (int p = 0; p < 2; p++) begin
            for (int n = 1; n <= 6; n++) begin
                @(negedge clk);
                want = (n == 4) ? (p == 0 ? 4'b1010 : 4'b1100) : 4'b0000;
                checks++;
                if (tick_a !== want || any_a !== (n == 4)) begin
                    failures++;
                    $display("FAIL all_ch p=%0d n=%0d got tick=%b any=%b want tick=%b any=%b",
                             p, n, tick_a, any_a, want, n == 4);
                end
            end
            level = 4'h0;
        end
    endtask

    task automatic test_set_wins();
        settle();
        mode     = 8'b00_00_01_00;
        level[1] = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            checks++;
            if (tick_a[1] !== (n == 4)) begin
                failures++;
                $display("FAIL setwin_tick n=%0d got=%b want=%b", n, tick_a[1], n == 4);
            end
            checks++;
            if (pend_a[1] !== (n == 5)) begin
                failures++;
                $display("FAIL setwin_pending n=%0d got=%b want=%b", n, pend_a[1], n == 5);
            end
            clr_pending[1] = (n == 4 || n == 5);
        end
    endtask

    task automatic test_reset_mid();
        settle();
        mode  = 8'h55;
        level = 4'hF;
        repeat (4) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({tick_a, pend_a, ldb_a, any_a, tick_b, pend_b, ldb_b, any_b} !== 26'd0) begin
            failures++;
            $display("FAIL reset_mid got a=%b/%b/%b/%b b=%b/%b/%b/%b want all zero",
                     tick_a, pend_a, ldb_a, any_a, tick_b, pend_b, ldb_b, any_b);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int n = 1; n <= 11; n++) begin
            @(negedge clk);
            checks++;
            if (tick_a !== (n == 4 ? 4'hF : 4'h0) || tick_b !== (n == 7 ? 4'hF : 4'h0)) begin
                failures++;
                $display("FAIL reset_relatency n=%0d got a=%b b=%b want a=%b b=%b", n, tick_a, tick_b,
                         n == 4 ? 4'hF : 4'h0, n == 7 ? 4'hF : 4'h0);
            end
        end
    endtask

    task automatic test_mode_switch();
        settle();
        mode     = 8'h01;
        level[0] = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            checks++;
            if (tick_a[0] !== 1'b0 || pend_a[0] !== 1'b0) begin
                failures++;
                $display("FAIL mode_switch n=%0d got tick=%b pend=%b want 0/0", n, tick_a[0], pend_a[0]);
            end
            if (n == 3) mode = 8'h00;
            if (n == 4) mode = 8'h01;
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            checks++;
            if (tick_a !== etick[0] || pend_a !== epend[0] || ldb_a !== mst[0] || any_a !== (|etick[0])) begin
                failures++;
                $display("FAIL rand_a n=%0d got t=%b p=%b d=%b any=%b want t=%b p=%b d=%b any=%b",
                         n, tick_a, pend_a, ldb_a, any_a, etick[0], epend[0], mst[0], |etick[0]);
            end
            checks++;
            if (tick_b !== etick[1] || pend_b !== epend[1] || ldb_b !== mst[1] || any_b !== (|etick[1])) begin
                failures++;
                $display("FAIL rand_b n=%0d got t=%b p=%b d=%b any=%b want t=%b p=%b d=%b any=%b",
                         n, tick_b, pend_b, ldb_b, any_b, etick[1], epend[1], mst[1], |etick[1]);
            end
            for (int c = 0; c < 4; c++)
                if ($urandom_range(0, 5) == 0) level[c] = ~level[c];
            if ($urandom_range(0, 15) == 0) mode = 8'($urandom());
            clr_pending = ($urandom_range(0, 7) == 0) ? 4'($urandom()) : 4'h0;
        end
    endtask

    initial begin
        test_reset();
        test_basic_rise();
        test_debounce();
        test_all_channels();
        test_set_wins();
        test_reset_mid();
        test_mode_switch();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
